fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch front end that drives the program counter's `en`/`dataInput` inputs and consumes its output.
- Issues one instruction-memory read per PC value over a valid/ready request and valid response interface.
- Computes the next PC: sequential step, or branch/jump redirect.
- Loads the IF/ID pipeline register; honours downstream stall and flush.

Parameters:
- ADDR_WIDTH, 32, PC and memory address width
- DATA_WIDTH, 32, instruction width
- PC_STEP, 4, sequential PC increment in bytes

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- pcValue  in  ADDR_WIDTH  current PC from program counter output
- pcEn  out  1  enable to program counter `en`
- pcNext  out  ADDR_WIDTH  next PC to program counter `dataInput`
- imemReqValid  out  1  read request valid
- imemReqReady  in  1  memory accepts request
- imemReqAddr  out  ADDR_WIDTH  read address
- imemRespValid  in  1  read data valid; one response per accepted request, in order
- imemRespData  in  DATA_WIDTH  instruction word
- stall  in  1  ID cannot accept; IF/ID must hold
- redirectValid  in  1  branch/jump taken, single-cycle pulse
- redirectTarget  in  ADDR_WIDTH  redirect PC
- ifidValid  out  1  IF/ID holds a valid instruction
- ifidInstr  out  DATA_WIDTH  IF/ID instruction
- ifidPc  out  ADDR_WIDTH  PC of ifidInstr
- ifidPcPlus4  out  ADDR_WIDTH  ifidPc + PC_STEP

Behaviour:
- Reset (async, rst=1):
  - state=REQ.
  - All IF/ID outputs 0; hold buffer 0; latched request PC (reqPc) 0.
  - pcEn, imemReqValid, pcNext and imemReqAddr are forced to 0 while rst=1.
- States: REQ, WAIT, HOLD, DRAIN. At most one request outstanding.
- REQ:
  - imemReqValid=1, imemReqAddr=pcValue.
  - On valid&ready: latch reqPc=pcValue and go to WAIT.
  - imemRespValid is ignored in REQ.
- WAIT, on imemRespValid:
  - If stall=0: load IF/ID (instr, reqPc, reqPc+PC_STEP, valid=1), pulse pcEn=1 with pcNext=reqPc+PC_STEP, go to REQ. The PC updates on the same edge, so REQ presents the new address the next cycle.
  - If stall=1: store the response in the hold buffer and go to HOLD; pcEn=0.
- HOLD: when stall=0, load IF/ID from the hold buffer, pulse pcEn with pcNext=reqPc+PC_STEP, go to REQ.
- IF/ID update rules:
  - stall=1: IF/ID holds all fields, including ifidValid.
  - stall=0 and no instruction delivered this cycle: ifidValid<=0 (bubble); other fields hold.
- Redirect (priority over everything, including stall):
  - pcEn=1, pcNext=redirectTarget.
  - ifidValid<=0 (flush); hold buffer discarded.
  - Next state:
    - From WAIT with no response this cycle: DRAIN.
    - From WAIT with a response this cycle: response discarded, go to REQ.
    - From REQ with the request accepted this cycle: DRAIN.
    - From REQ with no acceptance: REQ.
    - From HOLD: REQ.
    - From DRAIN: stay in DRAIN, unless imemRespValid is asserted this cycle, in which case discard it and go to REQ.
- DRAIN: imemReqValid=0; on imemRespValid discard the data and go to REQ. pcEn=0 except on redirect.
- pcEn is high only in the cycles stated above. pcNext=0 whenever pcEn=0.
- Arithmetic: reqPc+PC_STEP wraps modulo 2^ADDR_WIDTH (0xFFFFFFFC -> 0x00000000). redirectTarget passes through unaltered; no alignment check.
- Latency:
  - Request issue to IF/ID load = memory latency + 1 edge.
  - Zero-wait memory (ready=1, response the cycle after acceptance): one instruction every 2 cycles.

Decomposition:
- Shared package `fetch_pkg`:
  - state enum (REQ, WAIT, HOLD, DRAIN)
  - PC_STEP default
  - reset values of the IF/ID fields
- One sub-module, `ifid_register`: load/hold/flush register carrying valid, instr, pc, pcPlus4, with async active-high reset.
- FSM, hold buffer and next-PC logic live in `fetch_stage`.

Test Plan:
1. Reset, then memory response timing:
   - Assert rst mid-simulation → all outputs 0 immediately.
   - Release with pcValue=0 → imemReqValid=1, imemReqAddr=0x0 next cycle.
   - Memory ready=1, response 0xAAAA0001 one cycle later → ifidValid=1, ifidInstr=0xAAAA0001, ifidPc=0, ifidPcPlus4=4. One-cycle pcEn with pcNext=0x4.
2. Straight-line run, 4 instructions, zero-wait memory → ifidPc sequence 0x0, 0x4, 0x8, 0xC; ifidValid alternates 1/0.
3. stall=1 when response 0x12345678 arrives for PC 0x8:
   - pcEn stays 0; IF/ID unchanged; FSM in HOLD.
   - Drop stall 3 cycles later → ifidInstr=0x12345678, ifidPc=0x8, pcNext=0xC.
4. Redirect during an outstanding request:
   - redirectValid with target 0x100 in WAIT → pcEn=1, pcNext=0x100, ifidValid=0.
   - Late response 0xDEADBEEF is dropped, never reaches IF/ID.
   - Next imemReqAddr=0x100.
5. Simultaneous redirect and stall while IF/ID holds a valid instruction → flush wins: ifidValid=0, pcNext=redirectTarget.
6. pcValue=0xFFFFFFFC, response arrives → pcNext=0x00000000, ifidPcPlus4=0x00000000.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam int PC_STEP_DEFAULT = 4;

    localparam logic IFID_VALID_RST     = 1'b0;
    localparam logic IFID_FIELD_RST_BIT = 1'b0;

endpackage

// File: rtl/ifid_register.sv
// rtl/ifid_register.sv - IF/ID pipeline register with flush, hold and load
module ifid_register
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  hold,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_instr,
    input  logic [ADDR_WIDTH-1:0] load_pc,
    input  logic [ADDR_WIDTH-1:0] load_pc_plus,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pc_plus_q, pc_plus_d;

    // Flush clears only the valid bit; the payload fields keep their old contents.
    always_comb begin
        valid_d   = valid_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        pc_plus_d = pc_plus_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!hold) begin
            if (load) begin
                valid_d   = 1'b1;
                instr_d   = load_instr;
                pc_d      = load_pc;
                pc_plus_d = load_pc_plus;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= IFID_VALID_RST;
            instr_q   <= {DATA_WIDTH{IFID_FIELD_RST_BIT}};
            pc_q      <= {ADDR_WIDTH{IFID_FIELD_RST_BIT}};
            pc_plus_q <= {ADDR_WIDTH{IFID_FIELD_RST_BIT}};
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pc_plus_q <= pc_plus_d;
        end
    end

    assign valid   = valid_q;
    assign instr   = instr_q;
    assign pc      = pc_q;
    assign pc_plus = pc_plus_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch FSM, hold buffer and next-PC selection
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PC_STEP    = PC_STEP_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pcValue,
    output logic                  pcEn,
    output logic [ADDR_WIDTH-1:0] pcNext,
    output logic                  imemReqValid,
    input  logic                  imemReqReady,
    output logic [ADDR_WIDTH-1:0] imemReqAddr,
    input  logic                  imemRespValid,
    input  logic [DATA_WIDTH-1:0] imemRespData,
    input  logic                  stall,
    input  logic                  redirectValid,
    input  logic [ADDR_WIDTH-1:0] redirectTarget,
    output logic                  ifidValid,
    output logic [DATA_WIDTH-1:0] ifidInstr,
    output logic [ADDR_WIDTH-1:0] ifidPc,
    output logic [ADDR_WIDTH-1:0] ifidPcPlus4
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [DATA_WIDTH-1:0] hold_instr_q, hold_instr_d;

    logic                  req_valid;
    logic                  deliver;
    logic [DATA_WIDTH-1:0] deliver_instr;
    logic [ADDR_WIDTH-1:0] req_pc_plus;

    assign req_pc_plus = req_pc_q + ADDR_WIDTH'(PC_STEP);

    always_comb begin
        state_d       = state_q;
        req_pc_d      = req_pc_q;
        hold_instr_d  = hold_instr_q;
        req_valid     = 1'b0;
        deliver       = 1'b0;
        deliver_instr = imemRespData;

        case (state_q)
            ST_REQ: begin
                req_valid = 1'b1;
                if (imemReqReady) begin
                    req_pc_d = pcValue;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imemRespValid) begin
                    if (!stall) begin
                        deliver = 1'b1;
                        state_d = ST_REQ;
                    end else begin
                        hold_instr_d = imemRespData;
                        state_d      = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!stall) begin
                    deliver       = 1'b1;
                    deliver_instr = hold_instr_q;
                    state_d       = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (imemRespValid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase

        // A redirect kills any delivery; an in-flight request must be drained first.
        if (redirectValid) begin
            deliver      = 1'b0;
            hold_instr_d = hold_instr_q;
            case (state_q)
                ST_REQ:   state_d = imemReqReady ? ST_DRAIN : ST_REQ;
                ST_WAIT:  state_d = imemRespValid ? ST_REQ : ST_DRAIN;
                ST_HOLD:  state_d = ST_REQ;
                ST_DRAIN: state_d = imemRespValid ? ST_REQ : ST_DRAIN;
                default:  state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_REQ;
            req_pc_q     <= '0;
            hold_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    always_comb begin
        pcEn         = 1'b0;
        pcNext       = '0;
        imemReqValid = 1'b0;
        imemReqAddr  = '0;
        if (!rst) begin
            imemReqValid = req_valid;
            imemReqAddr  = pcValue;
            if (redirectValid) begin
                pcEn   = 1'b1;
                pcNext = redirectTarget;
            end else if (deliver) begin
                pcEn   = 1'b1;
                pcNext = req_pc_plus;
            end
        end
    end

    ifid_register #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ifid (
        .clk          (clk),
        .rst          (rst),
        .flush        (redirectValid),
        .hold         (stall),
        .load         (deliver),
        .load_instr   (deliver_instr),
        .load_pc      (req_pc_q),
        .load_pc_plus (req_pc_plus),
        .valid        (ifidValid),
        .instr        (ifidInstr),
        .pc           (ifidPc),
        .pc_plus      (ifidPcPlus4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcValue;
    logic        pcEn;
    logic [31:0] pcNext;
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemReqAddr;
    logic        imemRespValid;
    logic [31:0] imemRespData;
    logic        stall;
    logic        redirectValid;
    logic [31:0] redirectTarget;
    logic        ifidValid;
    logic [31:0] ifidInstr;
    logic [31:0] ifidPc;
    logic [31:0] ifidPcPlus4;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .pcValue        (pcValue),
        .pcEn           (pcEn),
        .pcNext         (pcNext),
        .imemReqValid   (imemReqValid),
        .imemReqReady   (imemReqReady),
        .imemReqAddr    (imemReqAddr),
        .imemRespValid  (imemRespValid),
        .imemRespData   (imemRespData),
        .stall          (stall),
        .redirectValid  (redirectValid),
        .redirectTarget (redirectTarget),
        .ifidValid      (ifidValid),
        .ifidInstr      (ifidInstr),
        .ifidPc         (ifidPc),
        .ifidPcPlus4    (ifidPcPlus4)
    );

    // Program counter register that the fetch stage steers.
    logic [31:0] pc_reg;
    always @(posedge clk or posedge rst) begin
        if (rst) pc_reg <= 32'd0;
        else if (pcEn) pc_reg <= pcNext;
    end
    assign pcValue = pc_reg;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        bit          stale;
    } req_t;

    req_t        outstanding[$];
    logic [31:0] dir_data[$];
    bit          held_v;
    logic [31:0] held_a, held_d;
    logic        m_valid;
    logic [31:0] m_instr, m_pc, m_pc4;
    logic        last_pcen;
    logic [31:0] last_pcnext;
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        outstanding.delete();
        held_v  = 0;
        held_a  = 0;
        held_d  = 0;
        m_valid = 0;
        m_instr = 0;
        m_pc    = 0;
        m_pc4   = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pcen"}, {31'd0, pcEn}, 32'd0);
        check({tag, "_pcnext"}, pcNext, 32'd0);
        check({tag, "_reqvalid"}, {31'd0, imemReqValid}, 32'd0);
        check({tag, "_reqaddr"}, imemReqAddr, 32'd0);
        check({tag, "_ifidvalid"}, {31'd0, ifidValid}, 32'd0);
        check({tag, "_ifidinstr"}, ifidInstr, 32'd0);
        check({tag, "_ifidpc"}, ifidPc, 32'd0);
        check({tag, "_ifidpc4"}, ifidPcPlus4, 32'd0);
    endtask

    // One clock: drive inputs, compare against the transaction model, advance it.
    task automatic step(input bit st, input bit rv, input logic [31:0] tgt,
                        input bit rdy, input int lat);
        bit          resp, drv, exp_req;
        req_t        e;
        logic [31:0] d_addr, d_data, exp_next;
        resp = (outstanding.size() > 0) && (outstanding[0].due == cyc);
        stall          = st;
        redirectValid  = rv;
        redirectTarget = tgt;
        imemReqReady   = rdy;
        imemRespValid  = resp;
        imemRespData   = resp ? outstanding[0].data : $urandom;
        #4;
        exp_req = (outstanding.size() == 0) && !held_v;
        drv = 0;
        d_addr = 0;
        d_data = 0;
        if (!rv && !st) begin
            if (held_v) begin
                drv = 1; d_addr = held_a; d_data = held_d;
            end else if (resp && !outstanding[0].stale) begin
                drv = 1; d_addr = outstanding[0].addr; d_data = outstanding[0].data;
            end
        end
        exp_next = rv ? tgt : (drv ? d_addr + 32'd4 : 32'd0);
        check("req_valid", {31'd0, imemReqValid}, {31'd0, exp_req});
        if (exp_req) check("req_addr", imemReqAddr, pcValue);
        check("pc_en", {31'd0, pcEn}, {31'd0, rv | drv});
        check("pc_next", pcNext, exp_next);
        check("ifid_valid", {31'd0, ifidValid}, {31'd0, m_valid});
        if (m_valid) begin
            check("ifid_instr", ifidInstr, m_instr);
            check("ifid_pc", ifidPc, m_pc);
            check("ifid_pc4", ifidPcPlus4, m_pc4);
        end
        last_pcen   = pcEn;
        last_pcnext = pcNext;

        if (resp) begin
            e = outstanding.pop_front();
            if (!e.stale && !rv && st) begin
                held_v = 1; held_a = e.addr; held_d = e.data;
            end
        end
        if (drv) held_v = 0;
        if (rv) begin
            held_v = 0;
            foreach (outstanding[i]) outstanding[i].stale = 1;
        end
        if (exp_req && rdy) begin
            e.addr  = pcValue;
            e.data  = (dir_data.size() > 0) ? dir_data.pop_front() : $urandom;
            e.due   = cyc + lat;
            e.stale = rv;
            outstanding.push_back(e);
        end
        if (rv) begin
            m_valid = 0;
        end else if (!st) begin
            if (drv) begin
                m_valid = 1; m_instr = d_data; m_pc = d_addr; m_pc4 = d_addr + 32'd4;
            end else begin
                m_valid = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic random_run(input int n);
        bit prev_rv = 0;
        bit rv;
        for (int i = 0; i < n; i++) begin
            rv = !prev_rv && ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 3) == 0, rv, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(1, 3));
            prev_rv = rv;
        end
    endtask

    initial begin
        rst = 1'b1;
        stall = 0; redirectValid = 0; redirectTarget = 0;
        imemReqReady = 0; imemRespValid = 0; imemRespData = 0;
        model_reset();
        dir_data = '{32'hAAAA0001, 32'h11110004, 32'h12345678, 32'hDEADBEEF,
                     32'h22220100, 32'h3333FFFC};
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all_zero("init_rst");
        rst = 1'b0;
        #1;
        check("t1_req_valid", {31'd0, imemReqValid}, 32'd1);
        check("t1_req_addr", imemReqAddr, 32'h0);

        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("t1_pcen", {31'd0, last_pcen}, 32'd1);
        check("t1_pcnext", last_pcnext, 32'h4);
        check("t1_valid", {31'd0, ifidValid}, 32'd1);
        check("t1_instr", ifidInstr, 32'hAAAA0001);
        check("t1_pc", ifidPc, 32'h0);
        check("t1_pc4", ifidPcPlus4, 32'h4);

        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        check("t3_pcen_stalled", {31'd0, last_pcen}, 32'd0);
        check("t3_pc_held", ifidPc, 32'h4);
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("t3_pcnext", last_pcnext, 32'hC);
        check("t3_instr", ifidInstr, 32'h12345678);
        check("t3_pc", ifidPc, 32'h8);

        step(0, 0, 0, 1, 2);
        step(0, 1, 32'h100, 1, 1);
        check("t4_pcen", {31'd0, last_pcen}, 32'd1);
        check("t4_pcnext", last_pcnext, 32'h100);
        step(0, 0, 0, 1, 1);
        check("t4_flushed", {31'd0, ifidValid}, 32'd0);
        check("t4_req_addr", imemReqAddr, 32'h100);

        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("t5_valid_before", {31'd0, ifidValid}, 32'd1);
        step(1, 1, 32'hFFFFFFFC, 0, 1);
        check("t5_pcnext", last_pcnext, 32'hFFFFFFFC);
        check("t5_flushed", {31'd0, ifidValid}, 32'd0);

        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("t6_pcnext_wrap", last_pcnext, 32'h0);
        check("t6_pc", ifidPc, 32'hFFFFFFFC);
        check("t6_pc4_wrap", ifidPcPlus4, 32'h0);

        random_run(3000);

        rst = 1'b1;
        stall = 0; redirectValid = 0; imemReqReady = 0; imemRespValid = 0;
        #1;
        check_all_zero("mid_rst");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rel_req_valid", {31'd0, imemReqValid}, 32'd1);
        check("rel_req_addr", imemReqAddr, 32'h0);

        random_run(1500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
